// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial packed-BCD adder: one digit per clock, FSM IDLE -> ADD -> DONE.
// Define BCD_SERIAL_CHECK_EN to reject operands containing a digit above 9 (raises err).
module bcd_serial_add_ctrl #(
  parameter int NDIGITS = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [4*NDIGITS-1:0]       A,
  input  logic [4*NDIGITS-1:0]       B,
  output logic                       busy,
  output logic                       done,
  output logic [4*(NDIGITS+1)-1:0]   F,
  output logic                       err
);

  localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NDIGITS - 1);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t              state, state_nxt;
  logic [4*NDIGITS-1:0] a_r, b_r;
  logic                carry, carry_nxt;
  logic [IW-1:0]       idx;
  logic [3:0]          a_dig, b_dig, sum_dig;
  logic [4:0]          s;
  logic                last, bad;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = bad ? DONE : ADD;
      ADD:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ADD);
    done = (state == DONE);
  end

  always_comb begin
    a_dig = '0;
    b_dig = '0;
    for (int d = 0; d < NDIGITS; d++) begin
      if (idx == IW'(d)) begin
        a_dig = a_r[4*d +: 4];
        b_dig = b_r[4*d +: 4];
      end
    end
  end

  // Decimal correction: +6 mod 16 wraps any sum above 9 back into BCD range.
  always_comb begin
    s = {1'b0, a_dig} + {1'b0, b_dig} + {4'b0000, carry};
    if (s > 5'd9) begin
      sum_dig   = s[3:0] + 4'd6;
      carry_nxt = 1'b1;
    end else begin
      sum_dig   = s[3:0];
      carry_nxt = 1'b0;
    end
    last = (idx == LAST);
  end

`ifdef BCD_SERIAL_CHECK_EN
  logic err_r;

  always_comb begin
    bad = 1'b0;
    for (int d = 0; d < NDIGITS; d++) begin
      if (A[4*d +: 4] > 4'd9 || B[4*d +: 4] > 4'd9) bad = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                        err_r <= 1'b0;
    else if (state == IDLE && start)  err_r <= bad;
  end

  assign err = err_r;
`else
  assign bad = 1'b0;
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      a_r   <= '0;
      b_r   <= '0;
      carry <= 1'b0;
      idx   <= '0;
      F     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_r   <= A;
            b_r   <= B;
            carry <= 1'b0;
            idx   <= '0;
            F     <= '0;
          end
        end
        ADD: begin
          for (int d = 0; d < NDIGITS; d++) begin
            if (idx == IW'(d)) F[4*d +: 4] <= sum_dig;
          end
          if (last) F[4*NDIGITS +: 4] <= {3'b000, carry_nxt};
          carry <= carry_nxt;
          idx   <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
